grf_wr_arbiter: RTL and testbench
=================================

GRF_WR_ARBITER -- requirements
Module: grf_wr_arbiter

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning the number of GRF registers cleared by the clear sequence (legal range 2..32).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports a_valid, b_valid  input  1  write request from requester A (ALU writeback) and requester B (load writeback).
REQ-005 SHALL have ports a_reg, b_reg  input  5  destination register of each request.
REQ-006 SHALL have ports a_data, b_data  input  32  write data of each request.
REQ-007 SHALL have ports a_ready, b_ready  output  1  request accepted this cycle.
REQ-008 SHALL have ports regwrite (output, 1), write_reg (output, 5) and write_data (output, 32), all driving the GRF write port.
REQ-009 SHALL have port clear_done  output  1  high once the block is in RUN.

Function
REQ-010 SHALL implement two states: CLEAR, in which registers are zeroed, and RUN, in which requesters are arbitrated.
REQ-011 SHALL accept a request only on the cycle its valid and ready are both high.
REQ-012 SHALL assert at most one of a_ready and b_ready per cycle; both SHALL be low in CLEAR.
REQ-013 SHALL generate ready combinationally from the valids and the priority pointer: a lone valid requester is granted; when both are valid, the requester holding priority is granted.
REQ-014 SHALL hand priority to the non-granted requester after every grant; priority SHALL be unchanged on cycles with no grant.
REQ-015 SHALL register the write port: a request accepted in cycle N gives regwrite=1 with that request's register number and data during cycle N+1; with no acceptance, regwrite=0 in cycle N+1.
REQ-016 SHALL accept a request with reg=0 (it consumes a grant and toggles priority) but SHALL drive regwrite=0 for it.
REQ-017 SHALL hold write_reg and write_data at their last values while regwrite=0.
REQ-018 SHALL use a 5-bit clear counter in CLEAR: each cycle it drives regwrite=1, write_reg=counter and write_data=0.
REQ-019 SHALL, in CLEAR, count 1..NREG-1, move to RUN in the cycle after the last clear write, and assert clear_done from the first RUN cycle onward.
REQ-020 SHALL treat requesters holding valid during CLEAR as stalled (ready=0), not dropped; they are served in RUN per REQ-013.

Reset
REQ-021 SHALL, while reset is low, force: state=CLEAR (or RUN when the macro is off), counter=1, priority=A, regwrite=0, write_reg=0, write_data=0, clear_done=0, a_ready=0, b_ready=0.
REQ-022 SHALL abort any write on reset assertion mid-operation, including mid-clear, and SHALL restart the clear sequence from register 1 after release.
REQ-023 SHALL not accept requests in the first clock edge after reset release unless the block is in RUN.

Configuration
REQ-024 SHALL honour macro GRF_CLEAR_EN: when defined, reset enters CLEAR and performs REQ-018/019; when undefined, reset enters RUN directly, clear_done=1 after reset release, and the clear counter logic is not built.

Verification
REQ-025 SHALL cover: GRF_CLEAR_EN defined, NREG=32, reset released -> regwrite=1 with write_reg=1..31 and write_data=0 on 31 consecutive cycles, then clear_done=1; a_valid held throughout -> a_ready=0 until RUN.
REQ-026 SHALL cover: RUN, a_valid only, a_reg=5, a_data=32'h1234_5678 -> a_ready=1 that cycle; next cycle regwrite=1, write_reg=5, write_data=32'h1234_5678.
REQ-027 SHALL cover: RUN, a_valid and b_valid held high for 4 cycles starting with priority=A -> grants A,B,A,B; write_reg alternates a_reg, b_reg.
REQ-028 SHALL cover: RUN, b_valid, b_reg=0, b_data=32'hFFFF_FFFF -> b_ready=1; next cycle regwrite=0; the following contended cycle grants A.
REQ-029 SHALL cover: reset asserted when write_reg=12 in CLEAR -> outputs go to reset values immediately; after release the clear restarts at write_reg=1.
REQ-030 SHALL cover: GRF_CLEAR_EN undefined -> clear_done=1 after reset release and the first a_valid is granted on the first post-reset cycle.

Source files
------------

// File: rtl/grf_wr_arbiter.sv
// GRF write-port arbiter: round-robin between ALU (A) and load (B) writeback, with an
// optional post-reset register clear sequence enabled by macro GRF_CLEAR_EN.
module grf_wr_arbiter #(
    parameter int unsigned NREG = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    output logic        a_ready,
    output logic        b_ready,
    output logic        regwrite,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        clear_done
);

    if (NREG < 2 || NREG > 32) begin : g_nreg_check
        $error("grf_wr_arbiter: NREG must be in 2..32");
    end

    logic        run;
    logic        clear_wr;
    logic [4:0]  clear_reg;
    logic        grant_a;
    logic        grant_b;
    logic        prio_b_q, prio_b_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic [31:0] write_data_q, write_data_d;

`ifdef GRF_CLEAR_EN
    typedef enum logic [0:0] {StClear, StRun} state_e;

    localparam logic [4:0] LastReg = 5'(NREG - 1);

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;

    // The last clear write is already on the port when we leave CLEAR, so RUN
    // starts the cycle after write_reg shows NREG-1.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear_wr = 1'b0;
        unique case (state_q)
            StClear: begin
                if (regwrite_q && (write_reg_q == LastReg)) begin
                    state_d = StRun;
                end else begin
                    clear_wr = 1'b1;
                    cnt_d    = cnt_q + 5'd1;
                end
            end
            StRun: begin
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StClear;
            cnt_q   <= 5'd1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign run       = (state_q == StRun);
    assign clear_reg = cnt_q;
`else
    // Without the clear sequence the block is always in RUN; only reset itself blocks grants.
    assign run       = reset;
    assign clear_wr  = 1'b0;
    assign clear_reg = 5'd0;
`endif

    assign grant_a = run && a_valid && (!b_valid || !prio_b_q);
    assign grant_b = run && b_valid && (!a_valid || prio_b_q);

    always_comb begin
        prio_b_d     = prio_b_q;
        regwrite_d   = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (clear_wr) begin
            regwrite_d   = 1'b1;
            write_reg_d  = clear_reg;
            write_data_d = 32'd0;
        end else if (grant_a) begin
            prio_b_d = 1'b1;
            // r0 is hardwired: the grant is consumed but nothing is written
            if (a_reg != 5'd0) begin
                regwrite_d   = 1'b1;
                write_reg_d  = a_reg;
                write_data_d = a_data;
            end
        end else if (grant_b) begin
            prio_b_d = 1'b0;
            if (b_reg != 5'd0) begin
                regwrite_d   = 1'b1;
                write_reg_d  = b_reg;
                write_data_d = b_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_b_q     <= 1'b0;
            regwrite_q   <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= 32'd0;
        end else begin
            prio_b_q     <= prio_b_d;
            regwrite_q   <= regwrite_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign regwrite   = regwrite_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;
    assign clear_done = run;

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Self-checking bench for grf_wr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_grf_wr_arbiter;

    localparam int unsigned NREG = 32;
`ifdef GRF_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid, b_valid;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        regwrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        clear_done;

    int n_checks = 0;
    int n_errors = 0;

    grf_wr_arbiter #(.NREG(NREG)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_reg      (a_reg),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_reg      (b_reg),
        .b_data     (b_data),
        .a_ready    (a_ready),
        .b_ready    (b_ready),
        .regwrite   (regwrite),
        .write_reg  (write_reg),
        .write_data (write_data),
        .clear_done (clear_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: expected write-port contents for the current cycle, who holds
    // priority, and how far the clear walk has got.
    bit          m_clearing = CLEAR_EN;
    int          m_next_clear = 1;
    bit          m_prio_b = 1'b0;
    bit          e_rw = 1'b0;
    logic [4:0]  e_reg = 5'd0;
    logic [31:0] e_data = 32'd0;

    always @(negedge clk) begin
        bit ga, gb, winner_b;
        if (!reset) begin
            m_clearing   = CLEAR_EN;
            m_next_clear = 1;
            m_prio_b     = 1'b0;
            e_rw         = 1'b0;
            e_reg        = 5'd0;
            e_data       = 32'd0;
            check("m_rst_regwrite", regwrite, 0);
            check("m_rst_write_reg", write_reg, 0);
            check("m_rst_write_data", write_data, 0);
            check("m_rst_clear_done", clear_done, 0);
            check("m_rst_a_ready", a_ready, 0);
            check("m_rst_b_ready", b_ready, 0);
        end else begin
            ga = 1'b0;
            gb = 1'b0;
            if (!m_clearing) begin
                if (a_valid && b_valid) begin
                    ga = !m_prio_b;
                    gb = m_prio_b;
                end else begin
                    ga = a_valid;
                    gb = b_valid;
                end
            end
            check("m_a_ready", a_ready, ga);
            check("m_b_ready", b_ready, gb);
            check("m_regwrite", regwrite, e_rw);
            check("m_write_reg", write_reg, e_reg);
            check("m_write_data", write_data, e_data);
            check("m_clear_done", clear_done, !m_clearing);
            e_rw = 1'b0;
            if (m_clearing) begin
                if (m_next_clear < NREG) begin
                    e_rw   = 1'b1;
                    e_reg  = m_next_clear[4:0];
                    e_data = 32'd0;
                    m_next_clear++;
                end else begin
                    m_clearing = 1'b0;
                end
            end else if (ga || gb) begin
                winner_b = gb;
                m_prio_b = !winner_b;
                if ((winner_b ? b_reg : a_reg) != 5'd0) begin
                    e_rw   = 1'b1;
                    e_reg  = winner_b ? b_reg : a_reg;
                    e_data = winner_b ? b_data : a_data;
                end
            end
        end
    end

    initial begin
        a_valid = 1'b1;
        a_reg   = 5'd7;
        a_data  = 32'hA5A5_0007;
        b_valid = 1'b0;
        b_reg   = 5'd0;
        b_data  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_clear_done", clear_done, 0);
        check("rst_a_ready", a_ready, 0);

        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
`ifdef GRF_CLEAR_EN
        check("clr_start_regwrite", regwrite, 0);
        check("clr_start_a_stall", a_ready, 0);
        for (int k = 1; k < NREG; k++) begin
            @(negedge clk);
            check("clr_regwrite", regwrite, 1);
            check("clr_write_reg", write_reg, k);
            check("clr_write_data", write_data, 0);
            check("clr_a_stall", a_ready, 0);
            check("clr_done_low", clear_done, 0);
        end
        @(negedge clk);
`endif
        check("run_clear_done", clear_done, 1);
        check("run_first_grant", a_ready, 1);
        @(posedge clk); #1 a_valid = 1'b0;
        @(negedge clk);
        check("first_wr_regwrite", regwrite, 1);
        check("first_wr_reg", write_reg, 7);

        // Lone A request
        @(posedge clk); #1;
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h1234_5678;
        @(negedge clk);
        check("lone_a_ready", a_ready, 1);
        check("lone_a_b_ready", b_ready, 0);
        @(posedge clk); #1 a_valid = 1'b0;
        @(negedge clk);
        check("lone_a_regwrite", regwrite, 1);
        check("lone_a_write_reg", write_reg, 5);
        check("lone_a_write_data", write_data, 32'h1234_5678);

        // B writes r0: grant taken, no write, priority passes to A
        @(posedge clk); #1;
        b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hFFFF_FFFF;
        @(negedge clk);
        check("r0_b_ready", b_ready, 1);
        check("r0_a_ready", a_ready, 0);
        @(posedge clk); #1;
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h3333_3333;
        b_reg = 5'd4; b_data = 32'h4444_4444;
        @(negedge clk);
        check("r0_regwrite", regwrite, 0);
        check("r0_write_reg_held", write_reg, 5);
        check("cont0_a_ready", a_ready, 1);
        check("cont0_b_ready", b_ready, 0);
        @(negedge clk);
        check("cont1_b_ready", b_ready, 1);
        check("cont1_a_ready", a_ready, 0);
        check("cont1_write_reg", write_reg, 3);
        @(negedge clk);
        check("cont2_a_ready", a_ready, 1);
        check("cont2_write_reg", write_reg, 4);
        @(negedge clk);
        check("cont3_b_ready", b_ready, 1);
        check("cont3_write_reg", write_reg, 3);
        @(posedge clk); #1 a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        check("cont_last_write_reg", write_reg, 4);
        check("cont_last_write_data", write_data, 32'h4444_4444);
        @(negedge clk);
        check("idle_regwrite", regwrite, 0);
        check("idle_write_reg_held", write_reg, 4);
        check("idle_write_data_held", write_data, 32'h4444_4444);

`ifdef GRF_CLEAR_EN
        // Reset in the middle of the clear walk restarts it from r1
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("midclr_write_reg", write_reg, 12);
        @(posedge clk); #1 reset = 1'b0;
        #1;
        check("midclr_rst_regwrite", regwrite, 0);
        check("midclr_rst_write_reg", write_reg, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("midclr_restart_idle", regwrite, 0);
        @(negedge clk);
        check("midclr_restart_regwrite", regwrite, 1);
        check("midclr_restart_reg", write_reg, 1);
`endif

        // Randomized traffic with occasional reset pulses
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset   = ($urandom_range(0, 249) != 0);
            a_valid = $urandom_range(0, 2) != 0;
            b_valid = $urandom_range(0, 2) != 0;
            a_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            b_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            a_data  = $urandom;
            b_data  = $urandom;
        end
        @(posedge clk); #1;
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
